// File: rtl/bram_kernel_read_control_unit.sv
// Port-B read controller for the kernel line BRAMs: waits for KERNEL_DIMM stored lines, streams one
// column per address through a 2-entry skid buffer, then releases the oldest line to the writer.
module bram_kernel_read_control_unit #(
  parameter  int KERNEL_DIMM = 3,
  parameter  int ADDR_WIDTH  = 4,
  parameter  int LINE_LEN    = 16,
  parameter  int DATA_WIDTH  = 8,
  localparam int SEL_W       = (KERNEL_DIMM > 1) ? $clog2(KERNEL_DIMM) : 1,
  localparam int CW          = KERNEL_DIMM * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  line_ready,
  input  logic                  new_frame,
  output logic                  en_b,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [CW-1:0]         rd_data_b,
  output logic [CW-1:0]         col_tdata,
  output logic                  col_tvalid,
  input  logic                  col_tready,
  output logic                  col_tlast,
  output logic                  line_done,
  output logic [SEL_W-1:0]      oldest_sel,
  output logic                  busy,
  output logic                  ovf
);

  localparam int PW = $clog2(KERNEL_DIMM + 1);
  localparam logic [PW-1:0]         PEND_FULL = PW'(KERNEL_DIMM);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LINE_LEN - 1);
  localparam logic [SEL_W-1:0]      SEL_MAX   = SEL_W'(KERNEL_DIMM - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t                state_q;
  logic [PW-1:0]         pend_q;
  logic [SEL_W-1:0]      oldest_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q, infl_last_q;
  logic [1:0]            cnt_q;
  logic [CW-1:0]         d0_q, d1_q;
  logic                  l0_q, l1_q;
  logic                  ovf_q, nf_q, line_done_q;

  logic       pop, issue, frame_clr;
  logic [2:0] occ;

  // A read may issue only if, after this cycle's pop, the buffer plus the in-flight read leaves room.
  always_comb begin
    pop       = (cnt_q != 2'd0) && col_tready;
    occ       = {1'b0, cnt_q} + {2'b00, inflight_q};
    issue     = (state_q == READ) && (occ < (pop ? 3'd3 : 3'd2));
    frame_clr = (new_frame && (state_q == IDLE)) ||
                ((state_q == DONE) && (nf_q || new_frame));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      oldest_q    <= '0;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      cnt_q       <= '0;
      d0_q        <= '0;
      d1_q        <= '0;
      l0_q        <= 1'b0;
      l1_q        <= 1'b0;
      ovf_q       <= 1'b0;
      nf_q        <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      if (frame_clr) begin
        pend_q <= '0;
      end else if (line_ready && !line_done_q) begin
        if (pend_q == PEND_FULL) ovf_q  <= 1'b1;
        else                     pend_q <= pend_q + PW'(1);
      end else if (line_done_q && !line_ready && (pend_q != '0)) begin
        pend_q <= pend_q - PW'(1);
      end

      line_done_q <= (state_q == DONE);

      if (state_q == DONE)                      nf_q <= 1'b0;
      else if (new_frame && (state_q != IDLE))  nf_q <= 1'b1;

      inflight_q <= issue;
      if (issue) infl_last_q <= (addr_q == LAST_ADDR);

      // line_done_q gates the restart so the release decrement lands before pend is re-examined.
      case (state_q)
        IDLE: begin
          if (new_frame) begin
            oldest_q <= '0;
          end else if (!line_done_q && (pend_q == PEND_FULL)) begin
            state_q <= READ;
            addr_q  <= '0;
          end
        end
        READ: begin
          if (issue) begin
            if (addr_q == LAST_ADDR) state_q <= DRAIN;
            else                     addr_q  <= addr_q + ADDR_WIDTH'(1);
          end
        end
        DRAIN: begin
          if (pop && l0_q) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
          if (nf_q || new_frame)      oldest_q <= '0;
          else if (oldest_q == SEL_MAX) oldest_q <= '0;
          else                        oldest_q <= oldest_q + SEL_W'(1);
        end
        default: state_q <= IDLE;
      endcase

      case ({inflight_q, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            d0_q <= rd_data_b;
            l0_q <= infl_last_q;
          end else begin
            d1_q <= rd_data_b;
            l1_q <= infl_last_q;
          end
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          d0_q  <= d1_q;
          l0_q  <= l1_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            d0_q <= rd_data_b;
            l0_q <= infl_last_q;
          end else begin
            d0_q <= d1_q;
            l0_q <= l1_q;
            d1_q <= rd_data_b;
            l1_q <= infl_last_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign en_b       = issue;
  assign addr_b     = addr_q;
  assign col_tdata  = d0_q;
  assign col_tvalid = (cnt_q != 2'd0);
  assign col_tlast  = l0_q && (cnt_q != 2'd0);
  assign line_done  = line_done_q;
  assign oldest_sel = oldest_q;
  assign busy       = (state_q != IDLE);
  assign ovf        = ovf_q;

endmodule
